// File: rtl/crossbar_allocator.sv
// crossbar_allocator: per-output round-robin arbiters with wormhole locking for a 5-port router.
// Optional per-output stall watchdog is compiled in when CBA_WATCHDOG_EN is defined.
module crossbar_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORTS-1:0]     req_valid,
  input  logic [NUM_PORTS-1:0]     req_head,
  input  logic [NUM_PORTS-1:0]     req_tail,
  input  logic [3*NUM_PORTS-1:0]   req_dest,
  input  logic [NUM_PORTS-1:0]     out_ready,
  output logic [NUM_PORTS-1:0]     grant,
  output logic [2:0]               north_out_select,
  output logic [2:0]               east_out_select,
  output logic [2:0]               south_out_select,
  output logic [2:0]               west_out_select,
  output logic [2:0]               local_out_select,
  output logic                     watchdog_err
);

  localparam logic [2:0] SEL_IDLE  = 3'b111;
  localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e               state_q [NUM_PORTS];
  state_e               state_d [NUM_PORTS];
  logic [2:0]           owner_q [NUM_PORTS];
  logic [2:0]           owner_d [NUM_PORTS];
  logic [2:0]           ptr_q   [NUM_PORTS];
  logic [2:0]           ptr_d   [NUM_PORTS];
  logic [2:0]           sel_q   [NUM_PORTS];
  logic [2:0]           sel_d   [NUM_PORTS];
  logic [2:0]           win_s   [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig_s  [NUM_PORTS];
  logic [NUM_PORTS-1:0] busy_s, grant_s, xfer_s, tail_s, found_s, force_s;
  logic                 match_s;

  function automatic logic [2:0] next_port(input logic [2:0] p);
    if (p >= LAST_PORT) begin
      return 3'd0;
    end else begin
      return p + 3'd1;
    end
  endfunction

  // Ownership map, per-output transfer detection and the combinational pop strobes.
  always_comb begin
    busy_s  = '0;
    grant_s = '0;
    xfer_s  = '0;
    tail_s  = '0;
    match_s = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        match_s    = (state_q[o] == LOCKED) && (owner_q[o] == 3'(i));
        busy_s[i]  = busy_s[i] | match_s;
        xfer_s[o]  = xfer_s[o] | (match_s & req_valid[i] & out_ready[o]);
        tail_s[o]  = tail_s[o] | (match_s & req_tail[i]);
        grant_s[i] = grant_s[i] | (match_s & req_valid[i] & out_ready[o]);
      end
    end
  end

  // Eligible head flits per output and the round-robin winner starting at ptr.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      found_s[o] = 1'b0;
      win_s[o]   = 3'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        elig_s[o][i] = req_valid[i] & req_head[i] & ~busy_s[i] &
                       (req_dest[3*i +: 3] == 3'(o));
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = (int'(ptr_q[o]) + k) % NUM_PORTS;
        if (!found_s[o] && elig_s[o][idx]) begin
          found_s[o] = 1'b1;
          win_s[o]   = 3'(idx);
        end else begin
          win_s[o]   = win_s[o];
        end
      end
    end
  end

`ifdef CBA_WATCHDOG_EN
  localparam int             CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  STALL_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q [NUM_PORTS];
  logic [CW-1:0] cnt_d [NUM_PORTS];
  logic          wd_q, wd_d;

  // Stall counters: the cycle that would reach TIMEOUT forces the output back to IDLE.
  always_comb begin
    wd_d = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      cnt_d[o]   = '0;
      force_s[o] = 1'b0;
      if ((state_q[o] == LOCKED) && !xfer_s[o]) begin
        if (cnt_q[o] >= STALL_LAST) begin
          force_s[o] = 1'b1;
          wd_d       = 1'b1;
        end else begin
          cnt_d[o]   = cnt_q[o] + CW'(1);
        end
      end else begin
        cnt_d[o] = '0;
      end
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) cnt_q[o] <= '0;
    end else begin
      wd_q <= wd_d;
      for (int o = 0; o < NUM_PORTS; o++) cnt_q[o] <= cnt_d[o];
    end
  end

  assign watchdog_err = wd_q;
`else
  // Without the watchdog a lock is only ever released by its tail flit.
  always_comb force_s = '0;

  assign watchdog_err = 1'b0;
`endif

  // Per-output IDLE/LOCKED next state; select follows the next state so it lines up with transfers.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      case (state_q[o])
        IDLE: begin
          if (found_s[o]) begin
            state_d[o] = LOCKED;
            owner_d[o] = win_s[o];
            ptr_d[o]   = next_port(win_s[o]);
          end else begin
            state_d[o] = IDLE;
          end
        end
        LOCKED: begin
          if ((xfer_s[o] && tail_s[o]) || force_s[o]) begin
            state_d[o] = IDLE;
          end else begin
            state_d[o] = LOCKED;
          end
        end
        default: state_d[o] = IDLE;
      endcase
      sel_d[o] = (state_d[o] == LOCKED) ? owner_d[o] : SEL_IDLE;
    end
  end

  // Arbiter state and registered select codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= 3'd0;
        ptr_q[o]   <= 3'd0;
        sel_q[o]   <= SEL_IDLE;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
        sel_q[o]   <= sel_d[o];
      end
    end
  end

  assign grant            = grant_s;
  assign north_out_select = sel_q[0];
  assign east_out_select  = sel_q[1];
  assign south_out_select = sel_q[2];
  assign west_out_select  = sel_q[3];
  assign local_out_select = sel_q[4];

endmodule

// File: tb/tb_crossbar_allocator.sv
// Directed testbench for crossbar_allocator; inputs change just after the falling edge,
// outputs are checked 1 time unit later.
module tb_crossbar_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_valid, req_head, req_tail, out_ready, grant;
  logic [14:0] req_dest;
  logic [2:0]  n_sel, e_sel, s_sel, w_sel, l_sel;
  logic        watchdog_err;
  logic [14:0] sels;

  int checks = 0;
  int fails  = 0;

  localparam logic [2:0]  I    = 3'b111;
  localparam logic [14:0] IDLE = 15'h7fff;

  always #5 clk = ~clk;

  assign sels = {l_sel, w_sel, s_sel, e_sel, n_sel};

  crossbar_allocator #(.NUM_PORTS(5), .TIMEOUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_head         (req_head),
    .req_tail         (req_tail),
    .req_dest         (req_dest),
    .out_ready        (out_ready),
    .grant            (grant),
    .north_out_select (n_sel),
    .east_out_select  (e_sel),
    .south_out_select (s_sel),
    .west_out_select  (w_sel),
    .local_out_select (l_sel),
    .watchdog_err     (watchdog_err)
  );

  function automatic logic [14:0] sv(input logic [2:0] n, input logic [2:0] e,
                                     input logic [2:0] s, input logic [2:0] w,
                                     input logic [2:0] l);
    return {l, w, s, e, n};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic h, input logic t,
                         input logic [2:0] d);
    req_valid[i]       = v;
    req_head[i]        = h;
    req_tail[i]        = t;
    req_dest[3*i +: 3] = d;
  endtask

  task automatic clr();
    req_valid = 5'b0;
    req_head  = 5'b0;
    req_tail  = 5'b0;
    req_dest  = 15'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr();
    out_ready = 5'b11111;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    out_ready = 5'b11111;

    // Reset state and idle release.
    @(negedge clk); #1;
    chk("rst_sel", 32'(sels), 32'(IDLE));
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_wd", 32'(watchdog_err), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_sel", 32'(sels), 32'(IDLE));
    chk("post_rst_grant", 32'(grant), 32'h0);

    // Single-flit W -> east.
    @(negedge clk); set_req(3, 1'b1, 1'b1, 1'b1, 3'd1); #1;
    chk("sf_arb_grant", 32'(grant), 32'h0);
    @(negedge clk); #1;
    chk("sf_sel", 32'(sels), 32'(sv(I, 3'b011, I, I, I)));
    chk("sf_grant", 32'(grant), 32'b01000);
    @(negedge clk); clr(); #1;
    chk("sf_release_sel", 32'(sels), 32'(IDLE));
    chk("sf_release_grant", 32'(grant), 32'h0);

    // Contention N, S, L -> east from ptr=0.
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b1, 3'd1);
    set_req(2, 1'b1, 1'b1, 1'b1, 3'd1);
    set_req(4, 1'b1, 1'b1, 1'b1, 3'd1);
    #1;
    chk("ct_arb_grant", 32'(grant), 32'h0);
    @(negedge clk); #1;
    chk("ct_n_grant", 32'(grant), 32'b00001);
    chk("ct_n_sel", 32'(sels), 32'(sv(I, 3'b000, I, I, I)));
    @(negedge clk); set_req(0, 1'b0, 1'b0, 1'b0, 3'd0); #1;
    chk("ct_gap1_sel", 32'(sels), 32'(IDLE));
    chk("ct_gap1_grant", 32'(grant), 32'h0);
    @(negedge clk); #1;
    chk("ct_s_grant", 32'(grant), 32'b00100);
    chk("ct_s_sel", 32'(sels), 32'(sv(I, 3'b010, I, I, I)));
    @(negedge clk); set_req(2, 1'b0, 1'b0, 1'b0, 3'd0); #1;
    chk("ct_gap2_sel", 32'(sels), 32'(IDLE));
    @(negedge clk); #1;
    chk("ct_l_grant", 32'(grant), 32'b10000);
    chk("ct_l_sel", 32'(sels), 32'(sv(I, 3'b100, I, I, I)));
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b1, 3'd1);
    set_req(4, 1'b1, 1'b1, 1'b1, 3'd1);
    #1;
    chk("ct_gap3_sel", 32'(sels), 32'(IDLE));
    @(negedge clk); #1;
    chk("ct_wrap_grant", 32'(grant), 32'b00001);
    chk("ct_wrap_sel", 32'(sels), 32'(sv(I, 3'b000, I, I, I)));
    @(negedge clk); clr(); #1;

    // Four-flit E -> local with two cycles of backpressure; N waits then wins.
    do_reset();
    @(negedge clk); set_req(1, 1'b1, 1'b1, 1'b0, 3'd4); #1;
    chk("mf_arb_grant", 32'(grant), 32'h0);
    @(negedge clk); #1;
    chk("mf_head_grant", 32'(grant), 32'b00010);
    chk("mf_head_sel", 32'(sels), 32'(sv(I, I, I, I, 3'b001)));
    @(negedge clk); set_req(1, 1'b1, 1'b0, 1'b0, 3'd4); #1;
    chk("mf_b1_grant", 32'(grant), 32'b00010);
    @(negedge clk); out_ready = 5'b01111; set_req(0, 1'b1, 1'b1, 1'b1, 3'd4); #1;
    chk("mf_bp1_grant", 32'(grant), 32'h0);
    chk("mf_bp1_sel", 32'(sels), 32'(sv(I, I, I, I, 3'b001)));
    @(negedge clk); #1;
    chk("mf_bp2_grant", 32'(grant), 32'h0);
    chk("mf_bp2_sel", 32'(sels), 32'(sv(I, I, I, I, 3'b001)));
    @(negedge clk); out_ready = 5'b11111; #1;
    chk("mf_b2_grant", 32'(grant), 32'b00010);
    @(negedge clk); set_req(1, 1'b1, 1'b0, 1'b1, 3'd4); #1;
    chk("mf_tail_grant", 32'(grant), 32'b00010);
    chk("mf_tail_sel", 32'(sels), 32'(sv(I, I, I, I, 3'b001)));
    @(negedge clk); set_req(1, 1'b0, 1'b0, 1'b0, 3'd0); #1;
    chk("mf_release_sel", 32'(sels), 32'(IDLE));
    chk("mf_release_grant", 32'(grant), 32'h0);
    @(negedge clk); #1;
    chk("mf_next_grant", 32'(grant), 32'b00001);
    chk("mf_next_sel", 32'(sels), 32'(sv(I, I, I, I, 3'b000)));

    // Out-of-range destination is never granted.
    @(negedge clk); clr(); set_req(3, 1'b1, 1'b1, 1'b1, 3'd5); #1;
    chk("bad_dest_grant0", 32'(grant), 32'h0);
    @(negedge clk); #1;
    chk("bad_dest_grant1", 32'(grant), 32'h0);
    chk("bad_dest_sel", 32'(sels), 32'(IDLE));

    // Parallel N->S and S->N, then reset mid-packet.
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b0, 3'd2);
    set_req(2, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    chk("par_arb_grant", 32'(grant), 32'h0);
    @(negedge clk); #1;
    chk("par_grant", 32'(grant), 32'b00101);
    chk("par_sel", 32'(sels), 32'(sv(3'b010, I, 3'b000, I, I)));
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 1'b0, 3'd2);
    set_req(2, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    chk("par_body_grant", 32'(grant), 32'b00101);
    #1 rst = 1'b1; #1;
    chk("par_rst_sel", 32'(sels), 32'(IDLE));
    chk("par_rst_grant", 32'(grant), 32'h0);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b0, 3'd2);
    set_req(2, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    chk("par_in_rst_grant", 32'(grant), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 3'd2);
    set_req(2, 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk); #1;
    chk("par_after_rst_grant", 32'(grant), 32'h0);
    chk("par_after_rst_sel", 32'(sels), 32'(IDLE));

    // Stalled lock on west: forced release with the watchdog, held forever without it.
    do_reset();
    @(negedge clk); out_ready = 5'b10111; set_req(1, 1'b1, 1'b1, 1'b0, 3'd3); #1;
    chk("wd_arb_grant", 32'(grant), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("wd_stall_sel", 32'(sels), 32'(sv(I, I, I, 3'b001, I)));
      chk("wd_stall_err", 32'(watchdog_err), 32'h0);
    end
    @(negedge clk); clr(); #1;
`ifdef CBA_WATCHDOG_EN
    chk("wd_fire_sel", 32'(sels), 32'(IDLE));
    chk("wd_fire_err", 32'(watchdog_err), 32'h1);
`else
    chk("wd_hold_sel", 32'(sels), 32'(sv(I, I, I, 3'b001, I)));
    chk("wd_hold_err", 32'(watchdog_err), 32'h0);
`endif
    @(negedge clk); #1;
    chk("wd_after_err", 32'(watchdog_err), 32'h0);
`ifdef CBA_WATCHDOG_EN
    chk("wd_after_sel", 32'(sels), 32'(IDLE));
`else
    chk("wd_after_sel", 32'(sels), 32'(sv(I, I, I, 3'b001, I)));
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
